// File: rtl/reg_file_pkg.sv
// Shared definitions for the banked register-pair file: logical pair indices,
// the pair type and the logical-to-physical slot function.
package reg_file_pkg;

    localparam int unsigned PKG_DW = 32'd8;

    localparam int unsigned IDX_AF = 32'd0;
    localparam int unsigned IDX_BC = 32'd1;
    localparam int unsigned IDX_DE = 32'd2;
    localparam int unsigned IDX_HL = 32'd3;
    localparam int unsigned IDX_IX = 32'd4;
    localparam int unsigned IDX_IY = 32'd5;
    localparam int unsigned IDX_WZ = 32'd6;
    localparam int unsigned IDX_SP = 32'd7;

    typedef logic [2*PKG_DW-1:0] pair_t;

    // Physical layout: slots 0..npair-1 are the primary/unbanked pairs,
    // slot npair+i is the alternate of banked pair i. Out of range -> npair+nalt.
    function automatic int unsigned phys_idx(
        input int unsigned lidx,
        input logic        b_af,
        input logic        b_main,
        input logic        swap,
        input int unsigned npair,
        input int unsigned nalt,
        input int unsigned idx_de,
        input int unsigned idx_hl
    );
        int unsigned slot;
        logic        bank;
        if (swap && (lidx == idx_de)) begin
            slot = idx_hl;
        end else if (swap && (lidx == idx_hl)) begin
            slot = idx_de;
        end else begin
            slot = lidx;
        end
        if (lidx == 32'd0) begin
            bank = b_af;
        end else if (lidx < nalt) begin
            bank = b_main;
        end else begin
            bank = 1'b0;
        end
        if (lidx >= npair) begin
            return npair + nalt;
        end else if (bank) begin
            return npair + slot;
        end else begin
            return slot;
        end
    endfunction

endpackage

// File: rtl/reg_file_map.sv
// Combinational logical-pair to physical-slot mapper driven by the exchange flags.
module reg_file_map
    import reg_file_pkg::*;
#(
    parameter int unsigned NPAIR  = 32'd8,
    parameter int unsigned NALT   = 32'd4,
    parameter int unsigned IDX_DE = 32'd2,
    parameter int unsigned IDX_HL = 32'd3,
    parameter int unsigned SELW   = 32'd3,
    parameter int unsigned PW     = 32'd4
) (
    input  logic [SELW-1:0] sel_i,
    input  logic            bank_af_i,
    input  logic            bank_main_i,
    input  logic [1:0]      dehl_swap_i,
    output logic [PW-1:0]   phys_o,
    output logic            valid_o
);

    assign valid_o = (32'(sel_i) < NPAIR);
    assign phys_o  = PW'(phys_idx(32'(sel_i), bank_af_i, bank_main_i,
                                  dehl_swap_i[bank_main_i],
                                  NPAIR, NALT, IDX_DE, IDX_HL));

endmodule

// File: rtl/reg_file_banked.sv
// Banked register-pair file with one-cycle exchanges done by remapping flags.
// Optional physical debug read port: define REG_FILE_BANKED_DBG_EN.
module reg_file_banked
    import reg_file_pkg::*;
#(
    parameter int unsigned DW      = 32'd8,
    parameter int unsigned NPAIR   = 32'd8,
    parameter int unsigned NALT    = 32'd4,
    parameter int unsigned IDX_DE  = 32'd2,
    parameter int unsigned IDX_HL  = 32'd3,
    parameter logic [DW-1:0] RST_VAL = '1,
    localparam int unsigned SELW   = (NPAIR > 32'd1) ? $clog2(NPAIR) : 32'd1,
    localparam int unsigned NPHYS  = NPAIR + NALT,
    localparam int unsigned PW     = $clog2(NPHYS)
) (
    input  logic            clk,
    input  logic            reset,
`ifdef REG_FILE_BANKED_DBG_EN
    input  logic [PW-1:0]   dbg_sel,
    output logic [2*DW-1:0] dbg_data,
`endif
    input  logic [SELW-1:0] wr_sel,
    input  logic            wr_en_hi,
    input  logic            wr_en_lo,
    input  logic [2*DW-1:0] wr_data,
    input  logic [SELW-1:0] rd_sel_a,
    input  logic [SELW-1:0] rd_sel_b,
    output logic [2*DW-1:0] rd_data_a,
    output logic [2*DW-1:0] rd_data_b,
    input  logic            ex_af,
    input  logic            exx,
    input  logic            ex_de_hl,
    output logic            bank_af,
    output logic            bank_main,
    output logic [1:0]      dehl_swap
);

    logic [2*DW-1:0] mem_q [NPHYS];
    logic            bank_af_q, bank_af_d;
    logic            bank_main_q, bank_main_d;
    logic [1:0]      dehl_swap_q, dehl_swap_d;
    logic [2*DW-1:0] rd_a_q, rd_a_d, rd_b_q, rd_b_d;

    logic [PW-1:0]   wr_phys_s, rd_a_phys_s, rd_b_phys_s;
    logic            wr_valid_s, rd_a_valid_s, rd_b_valid_s;

    reg_file_map #(.NPAIR(NPAIR), .NALT(NALT), .IDX_DE(IDX_DE), .IDX_HL(IDX_HL),
                   .SELW(SELW), .PW(PW)) u_map_wr (
        .sel_i(wr_sel), .bank_af_i(bank_af_q), .bank_main_i(bank_main_q),
        .dehl_swap_i(dehl_swap_q), .phys_o(wr_phys_s), .valid_o(wr_valid_s));

    reg_file_map #(.NPAIR(NPAIR), .NALT(NALT), .IDX_DE(IDX_DE), .IDX_HL(IDX_HL),
                   .SELW(SELW), .PW(PW)) u_map_rd_a (
        .sel_i(rd_sel_a), .bank_af_i(bank_af_q), .bank_main_i(bank_main_q),
        .dehl_swap_i(dehl_swap_q), .phys_o(rd_a_phys_s), .valid_o(rd_a_valid_s));

    reg_file_map #(.NPAIR(NPAIR), .NALT(NALT), .IDX_DE(IDX_DE), .IDX_HL(IDX_HL),
                   .SELW(SELW), .PW(PW)) u_map_rd_b (
        .sel_i(rd_sel_b), .bank_af_i(bank_af_q), .bank_main_i(bank_main_q),
        .dehl_swap_i(dehl_swap_q), .phys_o(rd_b_phys_s), .valid_o(rd_b_valid_s));

    // Read next-state: mapped slot with per-lane write-first bypass on a logical match.
    always_comb begin
        rd_a_d = '0;
        rd_b_d = '0;
        if (rd_a_valid_s) begin
            rd_a_d = mem_q[rd_a_phys_s];
        end else begin
            rd_a_d = '0;
        end
        if (rd_b_valid_s) begin
            rd_b_d = mem_q[rd_b_phys_s];
        end else begin
            rd_b_d = '0;
        end
        if (wr_valid_s && (wr_sel == rd_sel_a)) begin
            if (wr_en_hi) rd_a_d[2*DW-1:DW] = wr_data[2*DW-1:DW]; else rd_a_d = rd_a_d;
            if (wr_en_lo) rd_a_d[DW-1:0]    = wr_data[DW-1:0];    else rd_a_d = rd_a_d;
        end else begin
            rd_a_d = rd_a_d;
        end
        if (wr_valid_s && (wr_sel == rd_sel_b)) begin
            if (wr_en_hi) rd_b_d[2*DW-1:DW] = wr_data[2*DW-1:DW]; else rd_b_d = rd_b_d;
            if (wr_en_lo) rd_b_d[DW-1:0]    = wr_data[DW-1:0];    else rd_b_d = rd_b_d;
        end else begin
            rd_b_d = rd_b_d;
        end
    end

    // Exchange flags: DE/HL toggle targets the bank that is current before the edge.
    always_comb begin
        bank_af_d   = bank_af_q ^ ex_af;
        bank_main_d = bank_main_q ^ exx;
        dehl_swap_d = dehl_swap_q;
        dehl_swap_d[bank_main_q] = dehl_swap_q[bank_main_q] ^ ex_de_hl;
    end

    // Storage array: byte-lane writes into the pre-edge mapped slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(NPHYS); i++) begin
                mem_q[i] <= {2{RST_VAL}};
            end
        end else begin
            if (wr_valid_s && wr_en_hi) begin
                mem_q[wr_phys_s][2*DW-1:DW] <= wr_data[2*DW-1:DW];
            end
            if (wr_valid_s && wr_en_lo) begin
                mem_q[wr_phys_s][DW-1:0] <= wr_data[DW-1:0];
            end
        end
    end

    // Flag and read-data registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            bank_af_q   <= 1'b0;
            bank_main_q <= 1'b0;
            dehl_swap_q <= 2'b00;
            rd_a_q      <= '0;
            rd_b_q      <= '0;
        end else begin
            bank_af_q   <= bank_af_d;
            bank_main_q <= bank_main_d;
            dehl_swap_q <= dehl_swap_d;
            rd_a_q      <= rd_a_d;
            rd_b_q      <= rd_b_d;
        end
    end

    assign rd_data_a = rd_a_q;
    assign rd_data_b = rd_b_q;
    assign bank_af   = bank_af_q;
    assign bank_main = bank_main_q;
    assign dehl_swap = dehl_swap_q;

`ifdef REG_FILE_BANKED_DBG_EN
    assign dbg_data = (32'(dbg_sel) < NPHYS) ? mem_q[dbg_sel] : '0;
`endif

endmodule

// File: tb/tb_reg_file_banked.sv
// Bench for reg_file_banked: Z80-style data-moving reference model, directed + random stimulus.
module tb_reg_file_banked;
    import reg_file_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  wr_sel = 3'd0, rd_sel_a = 3'd0, rd_sel_b = 3'd0;
    logic        wr_en_hi = 1'b0, wr_en_lo = 1'b0;
    pair_t       wr_data = 16'h0000;
    pair_t       rd_data_a, rd_data_b;
    logic        ex_af = 1'b0, exx = 1'b0, ex_de_hl = 1'b0;
    logic        bank_af, bank_main;
    logic [1:0]  dehl_swap;
`ifdef REG_FILE_BANKED_DBG_EN
    logic [3:0]  dbg_sel = 4'd0;
    pair_t       dbg_data;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Reference: logical registers hold data; exchanges physically swap contents.
    pair_t cur [8];
    pair_t sh  [4];
    logic  m_af, m_main;
    logic [1:0] m_dehl;
    pair_t exp_a, exp_b;

    always #5 clk = ~clk;

    reg_file_banked dut (
        .clk(clk), .reset(reset),
`ifdef REG_FILE_BANKED_DBG_EN
        .dbg_sel(dbg_sel), .dbg_data(dbg_data),
`endif
        .wr_sel(wr_sel), .wr_en_hi(wr_en_hi), .wr_en_lo(wr_en_lo), .wr_data(wr_data),
        .rd_sel_a(rd_sel_a), .rd_sel_b(rd_sel_b),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .ex_af(ex_af), .exx(exx), .ex_de_hl(ex_de_hl),
        .bank_af(bank_af), .bank_main(bank_main), .dehl_swap(dehl_swap)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic pair_t rd_model(input logic [2:0] sel);
        pair_t v;
        v = cur[sel];
        if (wr_sel == sel) begin
            if (wr_en_hi) v[15:8] = wr_data[15:8];
            if (wr_en_lo) v[7:0]  = wr_data[7:0];
        end
        return v;
    endfunction

    // Apply one clock edge to the model and DUT, then compare everything.
    task automatic step();
        pair_t t;
        if (reset) begin
            for (int i = 0; i < 8; i++) cur[i] = 16'hFFFF;
            for (int i = 0; i < 4; i++) sh[i] = 16'hFFFF;
            m_af = 1'b0; m_main = 1'b0; m_dehl = 2'b00;
            exp_a = 16'h0000; exp_b = 16'h0000;
        end else begin
            exp_a = rd_model(rd_sel_a);
            exp_b = rd_model(rd_sel_b);
            if (wr_en_hi) cur[wr_sel][15:8] = wr_data[15:8];
            if (wr_en_lo) cur[wr_sel][7:0]  = wr_data[7:0];
            if (ex_af) begin
                t = cur[0]; cur[0] = sh[0]; sh[0] = t; m_af = ~m_af;
            end
            if (ex_de_hl) begin
                t = cur[2]; cur[2] = cur[3]; cur[3] = t; m_dehl[m_main] = ~m_dehl[m_main];
            end
            if (exx) begin
                for (int i = 1; i < 4; i++) begin
                    t = cur[i]; cur[i] = sh[i]; sh[i] = t;
                end
                m_main = ~m_main;
            end
        end
        @(posedge clk);
        #1;
        check_eq("rd_a", 32'(rd_data_a), 32'(exp_a));
        check_eq("rd_b", 32'(rd_data_b), 32'(exp_b));
        check_eq("bank_af", 32'(bank_af), 32'(m_af));
        check_eq("bank_main", 32'(bank_main), 32'(m_main));
        check_eq("dehl_swap", 32'(dehl_swap), 32'(m_dehl));
    endtask

    task automatic idle();
        reset = 1'b0; wr_en_hi = 1'b0; wr_en_lo = 1'b0;
        ex_af = 1'b0; exx = 1'b0; ex_de_hl = 1'b0;
    endtask

    task automatic wr(input logic [2:0] sel, input pair_t d);
        wr_sel = sel; wr_data = d; wr_en_hi = 1'b1; wr_en_lo = 1'b1;
        step();
        idle();
    endtask

    task automatic rd(input logic [2:0] a, input logic [2:0] b);
        rd_sel_a = a; rd_sel_b = b;
        step();
    endtask

    task automatic pulse(input logic af, input logic x, input logic dh);
        ex_af = af; exx = x; ex_de_hl = dh;
        step();
        idle();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        idle();
    endtask

    initial begin
        #1;
        do_reset();
        check_eq("reset_rd_a", 32'(rd_data_a), 32'h0);
        for (int i = 0; i < 8; i++) begin
            rd(3'(i), 3'(7 - i));
            check_eq("reset_pair", 32'(rd_data_a), 32'h0000FFFF);
        end

        // AF bank swap
        wr(3'(IDX_AF), 16'h1234);
        pulse(1'b1, 1'b0, 1'b0);
        wr(3'(IDX_AF), 16'h5678);
        pulse(1'b1, 1'b0, 1'b0);
        rd(3'(IDX_AF), 3'(IDX_AF));
        check_eq("af_primary", 32'(rd_data_a), 32'h1234);
        pulse(1'b1, 1'b0, 1'b0);
        rd(3'(IDX_AF), 3'(IDX_AF));
        check_eq("af_alt", 32'(rd_data_a), 32'h5678);

        // DE/HL exchange, per-bank swap state across exx
        do_reset();
        wr(3'(IDX_DE), 16'h1111);
        wr(3'(IDX_HL), 16'h2222);
        pulse(1'b0, 1'b0, 1'b1);
        rd(3'(IDX_DE), 3'(IDX_HL));
        check_eq("dehl_de", 32'(rd_data_a), 32'h2222);
        check_eq("dehl_hl", 32'(rd_data_b), 32'h1111);
        pulse(1'b0, 1'b1, 1'b0);
        rd(3'(IDX_DE), 3'(IDX_HL));
        check_eq("exx_de_alt", 32'(rd_data_a), 32'hFFFF);
        pulse(1'b0, 1'b1, 1'b0);
        rd(3'(IDX_DE), 3'(IDX_HL));
        check_eq("exx_de_back", 32'(rd_data_a), 32'h2222);
        pulse(1'b0, 1'b0, 1'b1);
        rd(3'(IDX_DE), 3'(IDX_HL));
        check_eq("dehl_twice", 32'(rd_data_a), 32'h1111);

        // Low-lane-only write with same-edge read bypass
        do_reset();
        wr_sel = 3'(IDX_HL); wr_data = 16'hABCD; wr_en_lo = 1'b1;
        rd_sel_a = 3'(IDX_HL); rd_sel_b = 3'(IDX_DE);
        step();
        idle();
        check_eq("lane_bypass", 32'(rd_data_a), 32'hFFCD);

        // Write and exx on the same edge use the old mapping
        do_reset();
        wr_sel = 3'(IDX_BC); wr_data = 16'h0F0F; wr_en_hi = 1'b1; wr_en_lo = 1'b1; exx = 1'b1;
        step();
        idle();
        rd(3'(IDX_BC), 3'(IDX_BC));
        check_eq("bc_after_exx", 32'(rd_data_a), 32'hFFFF);
        pulse(1'b0, 1'b1, 1'b0);
        rd(3'(IDX_BC), 3'(IDX_BC));
        check_eq("bc_back", 32'(rd_data_a), 32'h0F0F);

        // Reset wins over write and exchange on the same edge
        pulse(1'b1, 1'b0, 1'b1);
        reset = 1'b1; exx = 1'b1; wr_sel = 3'(IDX_SP); wr_data = 16'h1357;
        wr_en_hi = 1'b1; wr_en_lo = 1'b1;
        step();
        idle();
        check_eq("rst_flags", 32'({bank_af, bank_main, dehl_swap}), 32'h0);
        check_eq("rst_rd", 32'(rd_data_a), 32'h0);
        rd(3'(IDX_SP), 3'(IDX_BC));
        check_eq("rst_sp", 32'(rd_data_a), 32'hFFFF);

        // Random traffic, including back-to-back (held) exchange pulses
        for (int n = 0; n < 3000; n++) begin
            reset    = ($urandom_range(0, 199) == 0);
            wr_sel   = 3'($urandom_range(0, 7));
            wr_en_hi = 1'($urandom);
            wr_en_lo = 1'($urandom);
            wr_data  = 16'($urandom);
            rd_sel_a = ($urandom_range(0, 3) == 0) ? wr_sel : 3'($urandom_range(0, 7));
            rd_sel_b = 3'($urandom_range(0, 7));
            ex_af    = ($urandom_range(0, 5) == 0);
            exx      = ($urandom_range(0, 5) == 0);
            ex_de_hl = ($urandom_range(0, 5) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/reg_file_banked.md
Name: reg_file_banked

Overview:
- Parametrised register-pair file for the CPU datapath. Successor to the fixed Z80 register file.
- Holds NPAIR logical pairs of 2×DW bits. The first NALT pairs have an alternate bank. Physical pairs: NPAIR + NALT.
- Register exchanges (EX AF,AF' / EXX / EX DE,HL) are done in one cycle by toggling mapping flops. No data is moved.
- Sits between the register control unit and the address-side/data-side buses. Bus tri-stating is done outside this block.

Parameters:
- DW, 8, byte width of each half-register.
- NPAIR, 8, number of logical pairs (AF,BC,DE,HL,IX,IY,WZ,SP by index 0..7).
- NALT, 4, number of leading pairs that have an alternate bank. Legal range 1..NPAIR.
- IDX_DE, 2, logical index swapped by ex_de_hl (must be < NALT).
- IDX_HL, 3, partner index for ex_de_hl (must be < NALT).
- RST_VAL, all ones, reset value of every storage byte.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- wr_sel  in  SELW=$clog2(NPAIR)  logical pair to write
- wr_en_hi  in  1  write high byte
- wr_en_lo  in  1  write low byte
- wr_data  in  2*DW  write data {hi,lo}
- rd_sel_a / rd_sel_b  in  SELW  logical pair for read ports A/B
- rd_data_a / rd_data_b  out  2*DW  registered read data
- ex_af  in  1  pulse: toggle bank of pair 0
- exx  in  1  pulse: toggle bank of pairs 1..NALT-1
- ex_de_hl  in  1  pulse: swap IDX_DE/IDX_HL mapping in the current main bank
- bank_af, bank_main  out  1  current bank flags (0 = primary)
- dehl_swap  out  2  per-bank DE/HL swap flags

Behaviour:
- Reset (clk edge with reset=1): all storage = RST_VAL; bank_af=0, bank_main=0, dehl_swap=00; rd_data_a/b = 0. Reset overrides any write, read or exchange on the same edge.
- Mapping, combinational from current flags:
  - pair 0 → physical bank bank_af.
  - pairs 1..NALT-1 → bank bank_main.
  - If dehl_swap[bank_main]=1, IDX_DE and IDX_HL swap physical slots.
  - Pairs ≥ NALT are unbanked.
- Write: on a clk edge each enabled byte lane is stored into the physical slot given by the pre-edge mapping. Disabled lanes hold their value.
- Read: rd_data_x is registered, 1-cycle latency. The value is the content of the pre-edge mapped slot. Write-first bypass per lane: if the same logical pair is written on that edge, the enabled lanes return wr_data.
- Out-of-range select (index ≥ NPAIR): write ignored; read returns 0.
- Exchanges apply at the clk edge:
  - ex_af: bank_af ^= 1.
  - exx: bank_main ^= 1.
  - ex_de_hl: dehl_swap[bank_main] ^= 1, using the pre-edge bank_main.
- Any combination of exchange pulses may occur on the same edge; all apply. A write and a read on that edge use the pre-exchange mapping. The new mapping is visible from the next cycle.
- A held pulse toggles its flag on every edge. The control unit must pulse for exactly one cycle.
- ex_de_hl issued twice restores the original mapping. Each bank keeps its own DE/HL swap state across exx.

Optional Feature:
- Macro: REG_FILE_BANKED_DBG_EN.
- Defined: adds input dbg_sel (clog2(NPAIR+NALT) bits) and output dbg_data (2*DW bits).
  - dbg_data is a combinational read of the physical slot dbg_sel. It ignores all mapping flags.
  - Out-of-range dbg_sel reads 0.
- Undefined: neither port exists and there is no extra logic.

Decomposition:
- Package reg_file_pkg holds:
  - logical index constants IDX_AF..IDX_SP;
  - typedef pair_t (2*DW bits);
  - a function computing the physical index from (logical index, flags).
- One sub-module, reg_file_map: combinational logical→physical mapper. Instantiate it three times (write port, read port A, read port B).
- Storage and flags stay in the top module.

Test Plan:
- Reset, then read all 8 pairs → rd_data = 16'hFFFF each; flags all 0.
- Write AF=16'h1234; ex_af; write AF=16'h5678; ex_af; read AF → 16'h1234. ex_af again; read AF → 16'h5678.
- Write DE=16'h1111, HL=16'h2222; ex_de_hl; read DE → 16'h2222, HL → 16'h1111. exx; read DE → 16'hFFFF (alternate bank, unswapped). exx; read DE → 16'h2222.
- Same edge: write HL=16'hABCD with only wr_en_lo, and read HL on port A → rd_data_a = 16'hFFCD.
- Same edge: write BC=16'h0F0F and assert exx. Next cycle read BC → 16'hFFFF. exx; read BC → 16'h0F0F.
- Assert reset mid-sequence together with exx and a write → flags 0, storage FFFF, rd_data 0 on the next cycle.
